// File: rtl/led_pwm_fader.sv
// Four-channel LED fader: on/off requests become PWM drive whose duty ramps
// linearly toward full-on or full-off, one FADE_STEP per PWM period.
module led_pwm_fader #(
    parameter int PWM_BITS  = 8,
    parameter int PRESCALE  = 47,
    parameter int FADE_STEP = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic REQ1,
    input  logic REQ2,
    input  logic REQ3,
    input  logic REQ4,
    input  logic ENABLE,
    output logic PIN1,
    output logic PIN2,
    output logic PIN3,
    output logic PIN4,
    output logic BUSY
);

    localparam int PRE_W = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(PRESCALE);
    localparam logic [PWM_BITS-1:0] MAX      = '1;
    localparam logic [PWM_BITS:0]   MAX_X    = {1'b0, MAX};
    localparam logic [PWM_BITS:0]   STEP     = (PWM_BITS + 1)'(FADE_STEP);

    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic [PWM_BITS-1:0] duty_q [4];
    logic [PWM_BITS-1:0] duty_d [4];
    logic [PWM_BITS:0]   up_w   [4];
    logic [PWM_BITS:0]   dn_w   [4];
    logic [3:0]          pin_q, pin_d;
    logic                busy_q, busy_d;
    logic [3:0]          req;
    logic                tick;
    logic                period_end;

    always_comb begin
        req        = {REQ4, REQ3, REQ2, REQ1};
        tick       = (pre_q == PRE_LAST);
        period_end = tick && (cnt_q == MAX);
        pre_d      = tick ? '0 : pre_q + 1'b1;
        cnt_d      = tick ? cnt_q + 1'b1 : cnt_q;
        pin_d      = '0;
        busy_d     = 1'b0;
        for (int n = 0; n < 4; n++) begin
            up_w[n]   = {1'b0, duty_q[n]} + STEP;
            dn_w[n]   = {1'b0, duty_q[n]} - STEP;
            duty_d[n] = duty_q[n];
            // Duty only moves at the period boundary so no period is ever cut short.
            if (period_end) begin
                if (req[n] && duty_q[n] != MAX) begin
                    duty_d[n] = (up_w[n] > MAX_X) ? MAX : up_w[n][PWM_BITS-1:0];
                end else if (!req[n] && duty_q[n] != '0) begin
                    duty_d[n] = ({1'b0, duty_q[n]} < STEP) ? '0 : dn_w[n][PWM_BITS-1:0];
                end
            end
            pin_d[n] = ENABLE && ((duty_q[n] == MAX) || (cnt_q < duty_q[n]));
            if (duty_q[n] != (req[n] ? MAX : '0)) begin
                busy_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pre_q  <= '0;
            cnt_q  <= '0;
            pin_q  <= '0;
            busy_q <= 1'b0;
            for (int n = 0; n < 4; n++) begin
                duty_q[n] <= '0;
            end
        end else begin
            pre_q  <= pre_d;
            cnt_q  <= cnt_d;
            pin_q  <= pin_d;
            busy_q <= busy_d;
            for (int n = 0; n < 4; n++) begin
                duty_q[n] <= duty_d[n];
            end
        end
    end

    assign PIN1 = pin_q[0];
    assign PIN2 = pin_q[1];
    assign PIN3 = pin_q[2];
    assign PIN4 = pin_q[3];
    assign BUSY = busy_q;

endmodule

// File: tb/tb_led_pwm_fader.sv
// Bench for led_pwm_fader: per-cycle compare against an arithmetic model plus
// literal per-period high-count checks.
module tb_led_pwm_fader;

    localparam int PB    = 4;
    localparam int PRE   = 0;
    localparam int STEP  = 4;
    localparam int MAXV  = 15;
    localparam int PLEN  = 16;

    logic clk = 1'b0;
    logic rst;
    logic [3:0] req;
    logic en;
    logic pin1, pin2, pin3, pin4, busy;
    logic [3:0] pins;

    int n_cmp = 0;
    int n_bad = 0;
    bit check_en = 1'b0;

    int k;
    int duty [4];
    int shown_cnt = -1;
    logic [3:0] exp_pin;
    logic exp_busy;

    always #5 clk = ~clk;

    assign pins = {pin4, pin3, pin2, pin1};

    led_pwm_fader #(.PWM_BITS(PB), .PRESCALE(PRE), .FADE_STEP(STEP)) dut (
        .CLK(clk), .RST(rst),
        .REQ1(req[0]), .REQ2(req[1]), .REQ3(req[2]), .REQ4(req[3]),
        .ENABLE(en),
        .PIN1(pin1), .PIN2(pin2), .PIN3(pin3), .PIN4(pin4),
        .BUSY(busy)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: cnt follows from clocks since reset; duties ramp with saturating integer math.
    always @(posedge clk) begin
        int c;
        bit tk;
        if (rst) begin
            k = 0;
            for (int i = 0; i < 4; i++) duty[i] = 0;
            exp_pin   = '0;
            exp_busy  = 1'b0;
            shown_cnt = -1;
        end else begin
            c  = (k / (PRE + 1)) % PLEN;
            tk = ((k % (PRE + 1)) == PRE);
            exp_busy = 1'b0;
            for (int i = 0; i < 4; i++) begin
                exp_pin[i] = en && (duty[i] == MAXV || c < duty[i]);
                if (duty[i] != (req[i] ? MAXV : 0)) exp_busy = 1'b1;
            end
            if (tk && c == MAXV) begin
                for (int i = 0; i < 4; i++) begin
                    if (req[i]) duty[i] = (duty[i] + STEP > MAXV) ? MAXV : duty[i] + STEP;
                    else        duty[i] = (duty[i] - STEP < 0) ? 0 : duty[i] - STEP;
                end
            end
            shown_cnt = c;
            k++;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("pins", int'(pins), int'(exp_pin));
            check("busy", int'(busy), int'(exp_busy));
        end
    end

    task automatic measure(input int ch, input int exp_hi, input string name);
        int hi;
        int guard;
        hi = 0;
        guard = 0;
        @(negedge clk);
        while (shown_cnt != 0 && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 64) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: period alignment timed out after %0d clocks", name, guard);
        end else begin
            for (int i = 0; i < PLEN; i++) begin
                if (i > 0) @(negedge clk);
                hi += int'(pins[ch]);
            end
            check(name, hi, exp_hi);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req = 4'h0;
        en  = 1'b1;
        @(negedge clk);
        check_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset / idle
        repeat (100) @(negedge clk);
        check("idle pins", int'(pins), 0);
        check("idle busy", int'(busy), 0);

        // Fade-in
        req[0] = 1'b1;
        @(negedge clk);
        check("busy rise", int'(busy), 1);
        measure(0, 4,  "fadein p1");
        measure(0, 8,  "fadein p2");
        measure(0, 12, "fadein p3");
        measure(0, 16, "fadein p4");
        check("model d1 full", duty[0], 15);
        check("busy after fadein", int'(busy), 0);

        // Fade-out
        req[0] = 1'b0;
        measure(0, 16, "fadeout p0");
        measure(0, 11, "fadeout p1");
        measure(0, 7,  "fadeout p2");
        measure(0, 3,  "fadeout p3");
        measure(0, 0,  "fadeout p4");
        check("model d1 zero", duty[0], 0);

        // Reversal mid-fade
        req[0] = 1'b1;
        measure(0, 0, "rev p0");
        measure(0, 4, "rev p1");
        check("model d1 at reversal", duty[0], 8);
        req[0] = 1'b0;
        measure(0, 8, "rev p2");
        measure(0, 4, "rev p3");
        measure(0, 0, "rev p4");

        // Enable mask
        en  = 1'b0;
        req = 4'hF;
        repeat (80) @(negedge clk);
        check("masked pins", int'(pins), 0);
        check("masked busy done", int'(busy), 0);
        for (int i = 0; i < 4; i++) check("model full after mask", duty[i], 15);
        en = 1'b1;
        @(negedge clk);
        check("unmasked pins", int'(pins), 15);

        // Reset mid-fade
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req = 4'h1;
        measure(0, 0, "rstmid pre0");
        measure(0, 4, "rstmid pre1");
        check("model d1 before rst", duty[0], 8);
        rst = 1'b1;
        @(negedge clk);
        check("rst pin1", int'(pin1), 0);
        check("rst busy", int'(busy), 0);
        check("rst cnt", int'(dut.cnt_q), 0);
        rst = 1'b0;
        @(negedge clk);
        check("busy after rst", int'(busy), 1);
        measure(0, 4,  "rstmid p1");
        measure(0, 8,  "rstmid p2");
        measure(0, 12, "rstmid p3");
        measure(0, 16, "rstmid p4");

        @(negedge clk);
        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
